// File: rtl/cmd_fifo.sv
// Command queue ahead of top_control: buffers host READ/WRITE commands and presents the head entry FWFT.
// Define CMD_FIFO_ALMOST_FULL_EN to add the registered almost_full output (threshold AF_THRESH).
module cmd_fifo #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CMD_W     = 3,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned AF_THRESH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [CMD_W-1:0]           in_cmd,
  input  logic [ADDR_W-1:0]          in_addr,
  output logic                       in_ready,
  output logic                       fifo_valid,
  output logic [CMD_W-1:0]           fifo_cmd,
  output logic [ADDR_W-1:0]          fifo_addr,
  input  logic                       fifo_pop,
  output logic [$clog2(DEPTH):0]     count,
`ifdef CMD_FIFO_ALMOST_FULL_EN
  output logic                       almost_full,
`endif
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            empty, full, push, pop;
  entry_t          head;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = in_valid && !full;
  assign pop   = fifo_pop && !empty;

  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign in_ready   = !full;
  assign fifo_valid = !empty;
  assign fifo_cmd   = empty ? '0 : head.cmd;
  assign fifo_addr  = empty ? '0 : head.addr;
  assign count      = PW'(wr_ptr_q - rd_ptr_q);
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push)              wr_ptr_d    = wr_ptr_q + PW'(1);
    if (pop)               rd_ptr_d    = rd_ptr_q + PW'(1);
    if (in_valid && full)  overflow_d  = 1'b1;
    if (fifo_pop && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{cmd: in_cmd, addr: in_addr};
    end
  end

`ifdef CMD_FIFO_ALMOST_FULL_EN
  logic          almost_full_q, almost_full_d;
  logic [PW-1:0] count_next;

  // Look-ahead on next occupancy so the host is throttled one cycle early.
  always_comb begin
    count_next    = PW'(count + PW'(push) - PW'(pop));
    almost_full_d = (32'(count_next) >= AF_THRESH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) almost_full_q <= 1'b0;
    else     almost_full_q <= almost_full_d;
  end

  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_cmd_fifo.sv
// Directed self-checking bench for cmd_fifo (with or without CMD_FIFO_ALMOST_FULL_EN).
module tb_cmd_fifo;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CMD_W  = 3;
  localparam int unsigned ADDR_W = 32;
  localparam logic [CMD_W-1:0] CMD_NOP   = 3'b000;
  localparam logic [CMD_W-1:0] CMD_READ  = 3'b001;
  localparam logic [CMD_W-1:0] CMD_WRITE = 3'b010;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [CMD_W-1:0]  in_cmd;
  logic [ADDR_W-1:0] in_addr;
  logic              in_ready;
  logic              fifo_valid;
  logic [CMD_W-1:0]  fifo_cmd;
  logic [ADDR_W-1:0] fifo_addr;
  logic              fifo_pop;
  logic [3:0]        count;
  logic              overflow;
  logic              underflow;
`ifdef CMD_FIFO_ALMOST_FULL_EN
  logic              almost_full;
`endif

  int errors = 0;
  int checks = 0;

  cmd_fifo #(.DEPTH(DEPTH), .CMD_W(CMD_W), .ADDR_W(ADDR_W), .AF_THRESH(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_cmd     (in_cmd),
    .in_addr    (in_addr),
    .in_ready   (in_ready),
    .fifo_valid (fifo_valid),
    .fifo_cmd   (fifo_cmd),
    .fifo_addr  (fifo_addr),
    .fifo_pop   (fifo_pop),
    .count      (count),
`ifdef CMD_FIFO_ALMOST_FULL_EN
    .almost_full(almost_full),
`endif
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_cmd = '0; in_addr = '0; fifo_pop = 1'b0;
    #12;
    check("rst_valid", 64'(fifo_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_udf", 64'(underflow), 64'd0);
    check("rst_cmd", 64'(fifo_cmd), 64'(CMD_NOP));
    step();
    rst = 1'b0;

    // Single push latency
    in_valid = 1'b1; in_cmd = CMD_READ; in_addr = 32'h0000_1000;
    check("lat_pre_valid", 64'(fifo_valid), 64'd0);
    step();
    in_valid = 1'b0;
    check("lat_valid", 64'(fifo_valid), 64'd1);
    check("lat_cmd", 64'(fifo_cmd), 64'(CMD_READ));
    check("lat_addr", 64'(fifo_addr), 64'h1000);
    check("lat_count", 64'(count), 64'd1);
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    check("lat_drain", 64'(count), 64'd0);

    // Fill to full, then overflow attempt
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_cmd = CMD_WRITE; in_addr = 32'(32'h100 * i);
      step();
    end
    check("full_count", 64'(count), 64'd8);
    check("full_ready", 64'(in_ready), 64'd0);
    in_addr = 32'h900;
    step();
    in_valid = 1'b0;
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd8);
    check("ovf_head", 64'(fifo_addr), 64'h000);

    // Drain with fifo_pop held
    fifo_pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_addr%0d", i), 64'(fifo_addr), 64'(32'h100 * i));
      step();
    end
    fifo_pop = 1'b0;
    check("drain_valid", 64'(fifo_valid), 64'd0);
    check("drain_cmd", 64'(fifo_cmd), 64'(CMD_NOP));
    check("drain_addr", 64'(fifo_addr), 64'd0);
    check("drain_count", 64'(count), 64'd0);
    check("drain_udf", 64'(underflow), 64'd0);

    // Steady push+pop at count 3; pointers wrap several times
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_cmd = CMD_READ; in_addr = 32'(32'h2000 + 4 * k);
      step();
    end
    for (int j = 0; j < 20; j++) begin
      in_valid = 1'b1; in_addr = 32'(32'h2000 + 4 * (j + 3)); fifo_pop = 1'b1;
      check($sformatf("wrap_head%0d", j), 64'(fifo_addr), 64'(32'h2000 + 4 * j));
      check($sformatf("wrap_count%0d", j), 64'(count), 64'd3);
      step();
    end
    in_valid = 1'b0;
    for (int j = 20; j < 23; j++) begin
      check($sformatf("wrap_tail%0d", j), 64'(fifo_addr), 64'(32'h2000 + 4 * j));
      step();
    end
    fifo_pop = 1'b0;
    check("wrap_empty", 64'(count), 64'd0);
    check("wrap_udf", 64'(underflow), 64'd0);

    // Pop while empty
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    check("udf_flag", 64'(underflow), 64'd1);
    check("udf_count", 64'(count), 64'd0);
    check("udf_valid", 64'(fifo_valid), 64'd0);
    in_valid = 1'b1; in_cmd = CMD_WRITE; in_addr = 32'h3000;
    step();
    in_valid = 1'b0;
    check("udf_push_valid", 64'(fifo_valid), 64'd1);
    check("udf_push_addr", 64'(fifo_addr), 64'h3000);
    check("udf_push_cmd", 64'(fifo_cmd), 64'(CMD_WRITE));
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    check("udf_pop_count", 64'(count), 64'd0);
    check("udf_sticky", 64'(underflow), 64'd1);

    // Build count 5, exercise almost_full, then async reset
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_addr = 32'(32'h4000 + i);
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_count", 64'(count), 64'd5);
`ifdef CMD_FIFO_ALMOST_FULL_EN
    check("af_at5", 64'(almost_full), 64'd0);
    in_valid = 1'b1; in_addr = 32'h4005;
    step();
    in_valid = 1'b0;
    check("af_rise", 64'(almost_full), 64'd1);
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    check("af_fall", 64'(almost_full), 64'd0);
    check("af_count", 64'(count), 64'd5);
`endif
    check("pre_rst_ovf", 64'(overflow), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(fifo_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    check("arst_ovf", 64'(overflow), 64'd0);
    check("arst_udf", 64'(underflow), 64'd0);
`ifdef CMD_FIFO_ALMOST_FULL_EN
    check("arst_af", 64'(almost_full), 64'd0);
`endif
    step();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
